// File: rtl/tick_divider.sv
// Multi-channel programmable tick divider: each channel emits a one-cycle tick and a
// square wave every act+1 enabled cycles, with shadowed divisor updates applied on wrap.
module tick_divider #(
   parameter int unsigned         WIDTH       = 23,
   parameter int unsigned         NCH         = 2,
   parameter logic [WIDTH-1:0]    DEFAULT_DIV = 23'd5000000,
   parameter int unsigned         SELW        = 1
) (
   input  logic              fastclk,
   input  logic              reset,
   input  logic [NCH-1:0]    en,
   input  logic [NCH-1:0]    sclr,
   input  logic              div_we,
   input  logic [SELW-1:0]   div_sel,
   input  logic [WIDTH-1:0]  div_val,
   output logic [NCH-1:0]    tick,
   output logic [NCH-1:0]    sq
);

   logic [WIDTH-1:0] cnt_q [NCH];
   logic [WIDTH-1:0] cnt_d [NCH];
   logic [WIDTH-1:0] act_q [NCH];
   logic [WIDTH-1:0] act_d [NCH];
   logic [WIDTH-1:0] shd_q [NCH];
   logic [WIDTH-1:0] shd_d [NCH];
   logic [NCH-1:0]   sq_q;
   logic [NCH-1:0]   sq_d;

   always_comb begin
      logic wr;
      for (int ch = 0; ch < NCH; ch++) begin
         cnt_d[ch] = cnt_q[ch];
         act_d[ch] = act_q[ch];
         shd_d[ch] = shd_q[ch];
         sq_d[ch]  = sq_q[ch];
         // div_sel values beyond the last channel never match, so such writes vanish.
         wr = div_we && (div_sel == SELW'(ch));
         if (wr) begin
            shd_d[ch] = div_val;
         end
         if (sclr[ch]) begin
            cnt_d[ch] = '0;
            sq_d[ch]  = 1'b0;
            act_d[ch] = wr ? div_val : shd_q[ch];
         end else if (en[ch]) begin
            if (cnt_q[ch] == act_q[ch]) begin
               // Wrap edge: a coincident write bypasses the shadow straight into act.
               cnt_d[ch] = '0;
               sq_d[ch]  = ~sq_q[ch];
               act_d[ch] = wr ? div_val : shd_q[ch];
            end else begin
               cnt_d[ch] = cnt_q[ch] + WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         for (int ch = 0; ch < NCH; ch++) begin
            cnt_q[ch] <= '0;
            act_q[ch] <= DEFAULT_DIV;
            shd_q[ch] <= DEFAULT_DIV;
         end
         sq_q <= '0;
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            cnt_q[ch] <= cnt_d[ch];
            act_q[ch] <= act_d[ch];
            shd_q[ch] <= shd_d[ch];
         end
         sq_q <= sq_d;
      end
   end

   always_comb begin
      for (int ch = 0; ch < NCH; ch++) begin
         tick[ch] = !reset && en[ch] && !sclr[ch] && (cnt_q[ch] == '0);
      end
   end

   assign sq = sq_q;

endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider: a per-cycle reference model feeds an expected queue, plus
// directed timing checks for the divisor-update, enable, clear and reset scenarios.
module tb_tick_divider;

   localparam int W = 4;
   localparam int N = 3;
   localparam int S = 2;

   logic          fastclk = 1'b0;
   logic          reset;
   logic [N-1:0]  en;
   logic [N-1:0]  sclr;
   logic          div_we;
   logic [S-1:0]  div_sel;
   logic [W-1:0]  div_val;
   logic [N-1:0]  tick;
   logic [N-1:0]  sq;

   tick_divider #(
      .WIDTH(W), .NCH(N), .DEFAULT_DIV(4'd4), .SELW(S)
   ) dut (
      .fastclk(fastclk), .reset(reset), .en(en), .sclr(sclr),
      .div_we(div_we), .div_sel(div_sel), .div_val(div_val),
      .tick(tick), .sq(sq)
   );

   always #5 fastclk = ~fastclk;

   logic [W-1:0]   m_cnt [N];
   logic [W-1:0]   m_act [N];
   logic [W-1:0]   m_shd [N];
   logic [N-1:0]   m_sq;
   logic [2*N-1:0] exp_q [$];
   logic [N-1:0]   last_tick;
   logic [N-1:0]   last_sq;
   int             n_tests = 0;
   int             n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < N; ch++) begin
         m_cnt[ch] = '0;
         m_act[ch] = 4'd4;
         m_shd[ch] = 4'd4;
      end
      m_sq = '0;
   endtask

   function automatic logic [N-1:0] model_tick();
      logic [N-1:0] t;
      for (int ch = 0; ch < N; ch++) t[ch] = (m_cnt[ch] == 0) && en[ch] && !sclr[ch];
      return t;
   endfunction

   task automatic model_step();
      logic wr;
      for (int ch = 0; ch < N; ch++) begin
         wr = div_we && (int'(div_sel) == ch);
         if (sclr[ch]) begin
            m_cnt[ch] = '0;
            m_sq[ch]  = 1'b0;
            m_act[ch] = wr ? div_val : m_shd[ch];
         end else if (en[ch]) begin
            if (m_cnt[ch] == m_act[ch]) begin
               m_cnt[ch] = '0;
               m_sq[ch]  = ~m_sq[ch];
               m_act[ch] = wr ? div_val : m_shd[ch];
            end else begin
               m_cnt[ch] = m_cnt[ch] + 4'd1;
            end
         end
         if (wr) m_shd[ch] = div_val;
      end
   endtask

   // One clock: drive at negedge, compare outputs 1ns later, advance the model at posedge.
   task automatic cyc(input logic [N-1:0] e, input logic [N-1:0] s, input logic we,
                      input logic [S-1:0] sel, input logic [W-1:0] val);
      @(negedge fastclk);
      en = e; sclr = s; div_we = we; div_sel = sel; div_val = val;
      #1;
      exp_q.push_back({m_sq, model_tick()});
      last_tick = tick;
      last_sq   = sq;
      check_val("sb_sq_tick", {sq, tick}, exp_q.pop_front());
      @(posedge fastclk);
      model_step();
   endtask

   task automatic idle(input logic [N-1:0] e);
      cyc(e, '0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge fastclk);
      reset = 1'b1;
      #1;
      check_val("rst_tick", tick, 0);
      check_val("rst_sq", sq, 0);
      model_reset();
      repeat (2) begin
         @(negedge fastclk);
         check_val("rst_hold_tick", tick, 0);
      end
      @(posedge fastclk);
      #2 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = '1; sclr = '0; div_we = 1'b0; div_sel = '0; div_val = '0;
      model_reset();
      do_reset();

      // Default period, act=0 on a wrap edge (ch2), ignored out-of-range select, mid-period divisor change (ch0).
      for (int i = 0; i < 30; i++) begin
         if (i == 4)       cyc('1, '0, 1'b1, 2'd2, 4'd0);
         else if (i == 12) cyc('1, '0, 1'b1, 2'd3, 4'd1);
         else if (i == 22) cyc('1, '0, 1'b1, 2'd0, 4'd1);
         else              idle('1);
         if (i < 20) begin
            check_val("base_tick0", last_tick[0], (i % 5) == 0);
            check_val("base_sq0", last_sq[0], (i / 5) % 2);
         end else begin
            check_val("shadow_tick0", last_tick[0], i == 20 || i == 25 || i == 27 || i == 29);
         end
         if (i >= 5) check_val("act0_tick2", last_tick[2], 1);
         check_val("badsel_tick1", last_tick[1], (i % 5) == 0);
      end

      // Enable hold on ch1 at cnt=3.
      do_reset();
      repeat (3) idle('1);
      for (int k = 0; k < 7; k++) begin
         idle(3'b101);
         check_val("hold_tick1", last_tick[1], 0);
         check_val("hold_tick0", last_tick[0], ((3 + k) % 5) == 0);
      end
      for (int r = 0; r < 3; r++) begin
         idle('1);
         check_val("resume_tick1", last_tick[1], r == 2);
      end

      // Clear with simultaneous write on ch0.
      do_reset();
      repeat (2) idle('1);
      cyc('1, 3'b001, 1'b1, 2'd0, 4'd2);
      check_val("sclr_tick0", last_tick[0], 0);
      for (int k = 0; k < 7; k++) begin
         idle('1);
         check_val("sclrw_tick0", last_tick[0], (k % 3) == 0);
         check_val("sclrw_sq0", last_sq[0], (k / 3) % 2);
      end

      // Full-range divisor on ch1.
      do_reset();
      cyc('1, 3'b010, 1'b1, 2'd1, 4'd15);
      for (int k = 0; k < 34; k++) begin
         idle('1);
         check_val("full_tick1", last_tick[1], (k % 16) == 0);
      end

      // Reset discards a pending shadow value.
      do_reset();
      repeat (2) idle('1);
      cyc('1, '0, 1'b1, 2'd0, 4'd7);
      idle('1);
      do_reset();
      for (int i = 0; i < 12; i++) begin
         idle('1);
         check_val("rstshd_tick0", last_tick[0], (i % 5) == 0);
      end

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         logic [N-1:0] e;
         logic [N-1:0] s;
         for (int ch = 0; ch < N; ch++) begin
            e[ch] = $urandom_range(0, 3) != 0;
            s[ch] = $urandom_range(0, 15) == 0;
         end
         cyc(e, s, $urandom_range(0, 3) == 0, S'($urandom_range(0, 3)), W'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
